// File: rtl/aes_pkg.sv
// Shared AES definitions: key length encodings, round counts, controller states
// and S-box ownership codes.
package aes_pkg;

  localparam int unsigned KEYLEN_W = 2;

  localparam logic [KEYLEN_W-1:0] AES_128_BIT_KEY = 2'd0;
  localparam logic [KEYLEN_W-1:0] AES_192_BIT_KEY = 2'd1;
  localparam logic [KEYLEN_W-1:0] AES_256_BIT_KEY = 2'd2;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES192_ROUNDS = 12;
  localparam int unsigned AES256_ROUNDS = 14;

  localparam logic SBOX_SEL_KEYMEM = 1'b0;
  localparam logic SBOX_SEL_ENC    = 1'b1;

  typedef enum logic [2:0] {
    CTRL_IDLE        = 3'd0,
    CTRL_KEY_START   = 3'd1,
    CTRL_KEY_WAIT_LO = 3'd2,
    CTRL_KEY_WAIT_HI = 3'd3,
    CTRL_BLK_START   = 3'd4,
    CTRL_BLK_WAIT_LO = 3'd5,
    CTRL_BLK_WAIT_HI = 3'd6,
    CTRL_DONE        = 3'd7
  } ctrl_state_e;

  // Operation parameters captured when a request is accepted.
  typedef struct packed {
    logic [KEYLEN_W-1:0] keylen;
    logic                encdec;
  } ctrl_req_t;

  function automatic logic key_len_supported(input logic [KEYLEN_W-1:0] keylen);
    return (keylen == AES_128_BIT_KEY) || (keylen == AES_192_BIT_KEY) ||
           (keylen == AES_256_BIT_KEY);
  endfunction

endpackage

// File: rtl/aes_core_ctrl_if.sv
// Host request/status signals plus the key-memory and cipher start/ready handshakes.
interface aes_core_ctrl_if;
  import aes_pkg::*;

  logic                init;
  logic                next;
  logic [KEYLEN_W-1:0] keylen;
  logic                encdec;
  logic                ready;
  logic                key_valid;
  logic                result_valid;
  logic                error;
  logic [KEYLEN_W-1:0] keylen_o;
  logic                key_init_o;
  logic                key_ready_i;
  logic                enc_next_o;
  logic                enc_ready_i;
  logic                dec_next_o;
  logic                dec_ready_i;
  logic                sbox_sel;

  // Host and datapath side (drives requests and ready levels).
  modport master (
    output init, next, keylen, encdec, key_ready_i, enc_ready_i, dec_ready_i,
    input  ready, key_valid, result_valid, error, keylen_o, key_init_o,
           enc_next_o, dec_next_o, sbox_sel
  );

  // Controller side.
  modport slave (
    input  init, next, keylen, encdec, key_ready_i, enc_ready_i, dec_ready_i,
    output ready, key_valid, result_valid, error, keylen_o, key_init_o,
           enc_next_o, dec_next_o, sbox_sel
  );

endinterface

// File: rtl/aes_ctrl_watchdog.sv
// Wait-state cycle counter; expired flags the last permitted cycle of a wait.
module aes_ctrl_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_LAST);

endmodule

// File: rtl/aes_core_ctrl.sv
// AES sequencing controller: accepts key-init / block requests, pulses the key memory
// or cipher start, tracks the low-then-high ready handshake and aborts on a stall.
module aes_core_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic         clk,
  input logic         reset,
  aes_core_ctrl_if.slave bus
);

  ctrl_state_e state, state_next;
  ctrl_req_t   req_q, req_d;

  logic key_valid_q, key_valid_d;
  logic ready_q, ready_d;
  logic result_valid_q, result_valid_d;
  logic error_q, error_d;
  logic key_init_q, key_init_d;
  logic enc_next_q, enc_next_d;
  logic dec_next_q, dec_next_d;
  logic sbox_sel_q, sbox_sel_d;

  logic wd_clear, wd_enable, wd_expired;
  logic blk_ready;

  assign blk_ready = req_q.encdec ? bus.enc_ready_i : bus.dec_ready_i;

  aes_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CTRL_IDLE;
      req_q          <= '0;
      key_valid_q    <= 1'b0;
      ready_q        <= 1'b1;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      key_init_q     <= 1'b0;
      enc_next_q     <= 1'b0;
      dec_next_q     <= 1'b0;
      sbox_sel_q     <= SBOX_SEL_KEYMEM;
    end else begin
      state          <= state_next;
      req_q          <= req_d;
      key_valid_q    <= key_valid_d;
      ready_q        <= ready_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      key_init_q     <= key_init_d;
      enc_next_q     <= enc_next_d;
      dec_next_q     <= dec_next_d;
      sbox_sel_q     <= sbox_sel_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_next     = state;
    req_d          = req_q;
    key_valid_d    = key_valid_q;
    error_d        = 1'b0;
    ready_d        = 1'b0;
    result_valid_d = 1'b0;
    key_init_d     = 1'b0;
    enc_next_d     = 1'b0;
    dec_next_d     = 1'b0;
    sbox_sel_d     = SBOX_SEL_KEYMEM;
    wd_enable      = 1'b0;

    case (state)
      CTRL_IDLE: begin
        if (bus.init) begin
          if (key_len_supported(bus.keylen)) begin
            req_d.keylen = bus.keylen;
            key_valid_d  = 1'b0;
            state_next   = CTRL_KEY_START;
          end else begin
            error_d = 1'b1;
          end
        end else if (bus.next) begin
          if (key_valid_q) begin
            req_d.encdec = bus.encdec;
            state_next   = CTRL_BLK_START;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CTRL_KEY_START: state_next = CTRL_KEY_WAIT_LO;
      CTRL_KEY_WAIT_LO: begin
        wd_enable = 1'b1;
        if (!bus.key_ready_i) begin
          state_next = CTRL_KEY_WAIT_HI;
        end else if (wd_expired) begin
          error_d     = 1'b1;
          key_valid_d = 1'b0;
          state_next  = CTRL_IDLE;
        end
      end
      CTRL_KEY_WAIT_HI: begin
        wd_enable = 1'b1;
        if (bus.key_ready_i) begin
          key_valid_d = 1'b1;
          state_next  = CTRL_IDLE;
        end else if (wd_expired) begin
          error_d     = 1'b1;
          key_valid_d = 1'b0;
          state_next  = CTRL_IDLE;
        end
      end
      CTRL_BLK_START: state_next = CTRL_BLK_WAIT_LO;
      CTRL_BLK_WAIT_LO: begin
        wd_enable = 1'b1;
        if (!blk_ready) begin
          state_next = CTRL_BLK_WAIT_HI;
        end else if (wd_expired) begin
          error_d     = 1'b1;
          key_valid_d = 1'b0;
          state_next  = CTRL_IDLE;
        end
      end
      CTRL_BLK_WAIT_HI: begin
        wd_enable = 1'b1;
        if (blk_ready) begin
          state_next = CTRL_DONE;
        end else if (wd_expired) begin
          error_d     = 1'b1;
          key_valid_d = 1'b0;
          state_next  = CTRL_IDLE;
        end
      end
      CTRL_DONE: state_next = CTRL_IDLE;
      default:   state_next = CTRL_IDLE;
    endcase

    wd_clear       = (state_next != state);
    ready_d        = (state_next == CTRL_IDLE);
    result_valid_d = (state_next == CTRL_DONE);
    key_init_d     = (state_next == CTRL_KEY_START);
    enc_next_d     = (state_next == CTRL_BLK_START) &&  req_d.encdec;
    dec_next_d     = (state_next == CTRL_BLK_START) && !req_d.encdec;
    if ((state_next == CTRL_BLK_START) || (state_next == CTRL_BLK_WAIT_LO) ||
        (state_next == CTRL_BLK_WAIT_HI)) begin
      sbox_sel_d = req_d.encdec ? SBOX_SEL_ENC : SBOX_SEL_KEYMEM;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.key_valid    = key_valid_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.keylen_o     = req_q.keylen;
  assign bus.key_init_o   = key_init_q;
  assign bus.enc_next_o   = enc_next_q;
  assign bus.dec_next_o   = dec_next_q;
  assign bus.sbox_sel     = sbox_sel_q;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Bench for aes_core_ctrl: directed vector table, randomized transactions against a
// rule-level outcome model, and reset / mid-operation reset sequences.
module tb_aes_core_ctrl;
  import aes_pkg::*;

  localparam int TO      = 64;
  localparam int OP_INIT = 1;
  localparam int OP_NEXT = 2;
  localparam int OP_BOTH = 3;
  localparam int BUDGET  = 400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_core_ctrl_if bus();
  aes_core_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int op; int keylen; int encdec; int dlo; int dhi;
    int err_edge; int res_edge; int ready_edge; int kv; int keylen_o;
    int n_kinit; int n_enc; int n_dec;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int kv_m, klen_m;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int op, input int kl, input int ed, input int dlo,
                              input int dhi, input int err, input int res, input int rdy,
                              input int kv, input int klo, input int ki, input int en,
                              input int de);
    vec_t v;
    v.op = op; v.keylen = kl; v.encdec = ed; v.dlo = dlo; v.dhi = dhi;
    v.err_edge = err; v.res_edge = res; v.ready_edge = rdy; v.kv = kv; v.keylen_o = klo;
    v.n_kinit = ki; v.n_enc = en; v.n_dec = de;
    return v;
  endfunction

  // Outcome from the request rules. Edge n counts clock edges after the one that
  // sampled the request; the responder drops ready dlo+1 edges after seeing the start
  // pulse and raises it dhi edges after the drop.
  function automatic vec_t model(input vec_t s, input int kv, input int klen);
    vec_t e;
    bit go, is_blk;
    e = s;
    e.err_edge = -1; e.res_edge = -1; e.ready_edge = 0; e.kv = kv; e.keylen_o = klen;
    e.n_kinit = 0; e.n_enc = 0; e.n_dec = 0;
    go = 1'b0; is_blk = 1'b0;
    if (s.op == OP_INIT || s.op == OP_BOTH) begin
      if (s.keylen == 3) e.err_edge = 0;
      else begin e.n_kinit = 1; e.keylen_o = s.keylen; go = 1'b1; end
    end else if (kv == 0) begin
      e.err_edge = 0;
    end else begin
      if (s.encdec != 0) e.n_enc = 1; else e.n_dec = 1;
      go = 1'b1; is_blk = 1'b1;
    end
    if (go) begin
      if (s.dlo > TO - 1) begin
        e.err_edge = 1 + TO; e.ready_edge = e.err_edge; e.kv = 0;
      end else if (s.dhi > TO) begin
        e.err_edge = 2 + s.dlo + TO; e.ready_edge = e.err_edge; e.kv = 0;
      end else if (is_blk) begin
        e.res_edge = 2 + s.dlo + s.dhi; e.ready_edge = e.res_edge + 1;
      end else begin
        e.ready_edge = 2 + s.dlo + s.dhi; e.kv = 1;
      end
    end
    return e;
  endfunction

  task automatic run_txn(input vec_t v, input string tag, input int idx);
    int p, ch, err_edge, res_edge, ready_edge, n_err, n_res, n_ki, n_en, n_de, sbox_bad;
    int sbox_end;
    bit blk;
    logic exp_s;
    string nm;
    nm = $sformatf("%s[%0d]", tag, idx);
    p = -1; ch = 0; err_edge = -1; res_edge = -1; ready_edge = -1;
    n_err = 0; n_res = 0; n_ki = 0; n_en = 0; n_de = 0; sbox_bad = 0;
    blk = (v.n_enc + v.n_dec) > 0;
    sbox_end = (v.res_edge >= 0) ? v.res_edge : v.ready_edge;
    bus.key_ready_i = 1'b1; bus.enc_ready_i = 1'b1; bus.dec_ready_i = 1'b1;
    bus.init   = (v.op == OP_INIT || v.op == OP_BOTH);
    bus.next   = (v.op == OP_NEXT || v.op == OP_BOTH);
    bus.keylen = 2'(v.keylen);
    bus.encdec = 1'(v.encdec);
    step();
    bus.init = 1'b0; bus.next = 1'b0;
    for (int n = 0; n <= BUDGET && ready_edge < 0; n++) begin
      if (n > 0) step();
      if (bus.key_init_o) begin n_ki++; p = n; ch = 0; end
      if (bus.enc_next_o) begin n_en++; p = n; ch = 1; end
      if (bus.dec_next_o) begin n_de++; p = n; ch = 2; end
      if (bus.error) begin n_err++; err_edge = n; end
      if (bus.result_valid) begin n_res++; res_edge = n; end
      exp_s = (blk && n < sbox_end) ? 1'(v.encdec) : 1'b0;
      if (bus.sbox_sel !== exp_s) sbox_bad++;
      if (bus.ready) ready_edge = n;
      if (p >= 0 && ready_edge < 0) begin
        if (n == p + 1 + v.dlo) begin
          case (ch)
            0: bus.key_ready_i = 1'b0;
            1: bus.enc_ready_i = 1'b0;
            default: bus.dec_ready_i = 1'b0;
          endcase
        end
        if (n == p + 1 + v.dlo + v.dhi) begin
          bus.key_ready_i = 1'b1; bus.enc_ready_i = 1'b1; bus.dec_ready_i = 1'b1;
        end
      end
    end
    chk({nm, " ready_edge"}, ready_edge, v.ready_edge);
    chk({nm, " err_edge"}, err_edge, v.err_edge);
    chk({nm, " res_edge"}, res_edge, v.res_edge);
    chk({nm, " err_pulses"}, n_err, (v.err_edge >= 0) ? 1 : 0);
    chk({nm, " res_pulses"}, n_res, (v.res_edge >= 0) ? 1 : 0);
    chk({nm, " key_valid"}, int'(bus.key_valid), v.kv);
    chk({nm, " keylen_o"}, int'(bus.keylen_o), v.keylen_o);
    chk({nm, " key_init_pulses"}, n_ki, v.n_kinit);
    chk({nm, " enc_next_pulses"}, n_en, v.n_enc);
    chk({nm, " dec_next_pulses"}, n_de, v.n_dec);
    chk({nm, " sbox_sel_bad"}, sbox_bad, 0);
    bus.key_ready_i = 1'b1; bus.enc_ready_i = 1'b1; bus.dec_ready_i = 1'b1;
    step();
    chk({nm, " pulses_cleared"},
        int'(bus.error | bus.result_valid | bus.key_init_o | bus.enc_next_o | bus.dec_next_o), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    vec_t s, e;
    bus.init = 1'b0; bus.next = 1'b0; bus.keylen = 2'd0; bus.encdec = 1'b0;
    bus.key_ready_i = 1'b1; bus.enc_ready_i = 1'b1; bus.dec_ready_i = 1'b1;

    // Reset and idle.
    reset = 1'b1;
    step();
    chk("reset ready", int'(bus.ready), 1);
    chk("reset key_valid", int'(bus.key_valid), 0);
    step();
    reset = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc += int'(bus.result_valid | bus.error | bus.key_init_o | bus.enc_next_o |
                  bus.dec_next_o | bus.sbox_sel | !bus.ready | bus.key_valid);
    end
    chk("idle outputs_bad", acc, 0);
    chk("idle keylen_o", int'(bus.keylen_o), 0);

    // Directed vectors (TIMEOUT_CYCLES = 64).
    tbl[0]  = mk(OP_NEXT, 0, 1,   1,  1,  0, -1,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(OP_INIT, 3, 0,   1,  1,  0, -1,   0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(OP_INIT, 1, 0,   1, 14, -1, -1,  17, 1, 1, 1, 0, 0);
    tbl[3]  = mk(OP_NEXT, 0, 1,   1, 12, -1, 15,  16, 1, 1, 0, 1, 0);
    tbl[4]  = mk(OP_NEXT, 0, 0,   3,  5, -1, 10,  11, 1, 1, 0, 0, 1);
    tbl[5]  = mk(OP_INIT, 3, 1,   1,  1,  0, -1,   0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(OP_BOTH, 2, 1,   0,  1, -1, -1,   3, 1, 2, 1, 0, 0);
    tbl[7]  = mk(OP_INIT, 0, 0, 100,  1, 65, -1,  65, 0, 0, 1, 0, 0);
    tbl[8]  = mk(OP_NEXT, 0, 1,   1,  1,  0, -1,   0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(OP_INIT, 2, 0,  63, 64, -1, -1, 129, 1, 2, 1, 0, 0);
    tbl[10] = mk(OP_NEXT, 0, 1,   0, 65, 66, -1,  66, 0, 2, 0, 1, 0);
    tbl[11] = mk(OP_INIT, 0, 0,   2,  3, -1, -1,   7, 1, 0, 1, 0, 0);
    tbl[12] = mk(OP_NEXT, 0, 0,  64,  1, 65, -1,  65, 0, 0, 0, 0, 1);
    tbl[13] = mk(OP_INIT, 1, 0,   0, 64, -1, -1,  66, 1, 1, 1, 0, 0);
    tbl[14] = mk(OP_NEXT, 0, 1,  63,  1, -1, 66,  67, 1, 1, 0, 1, 0);
    for (int i = 0; i < 15; i++) run_txn(tbl[i], "vec", i);
    kv_m = 1; klen_m = 1;

    // Randomized transactions against the rule model.
    for (int r = 0; r < 40; r++) begin
      s = mk(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      s.dlo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(0, 6));
      s.dhi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 68)) : int'($urandom_range(1, 8));
      e = model(s, kv_m, klen_m);
      run_txn(e, "rnd", r);
      kv_m = e.kv; klen_m = e.keylen_o;
    end

    // Reset while waiting for the encipher ready to rise.
    e = model(mk(OP_INIT, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), kv_m, klen_m);
    run_txn(e, "pre_reset", 0);
    bus.next = 1'b1; bus.encdec = 1'b1;
    step();
    bus.next = 1'b0;
    step();
    step();
    bus.enc_ready_i = 1'b0;
    step(); step(); step();
    chk("midrst busy_ready", int'(bus.ready), 0);
    chk("midrst busy_sbox", int'(bus.sbox_sel), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst ready", int'(bus.ready), 1);
    chk("midrst key_valid", int'(bus.key_valid), 0);
    chk("midrst sbox_sel", int'(bus.sbox_sel), 0);
    bus.enc_ready_i = 1'b1;
    acc = int'(bus.result_valid | bus.error);
    for (int i = 0; i < 20; i++) begin
      step();
      acc += int'(bus.result_valid | bus.error | bus.enc_next_o | bus.dec_next_o |
                  bus.key_init_o | !bus.ready);
    end
    chk("midrst quiet_after", acc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
